tft_frame_feeder: RTL
=====================

// Module: tft_frame_feeder
// PURPOSE
//  Upstream word source for TFT_SPI: performs panel hard reset, replays an init command ROM,
//  programs the address window (CASET/RASET/RAMWR), then streams RGB565 pixels from a
//  framebuffer read port. Every SPI item is handed to TFT_SPI over a valid/ready handshake,
//  with a D/C flag and a byte/word size flag.
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  sys_clk_i frequency; sets ms tick divider CLK_FREQ_HZ/1000
//  H_RES        160         pixels per line
//  V_RES        128         lines per frame
//  INIT_LEN     32          init ROM entries (depth of tft_init_rom)
//  RST_LOW_MS   10          tft_rst_no low time
//  RST_WAIT_MS  120         wait after tft_rst_no release
// PORTS
//  sys_clk_i      in   1   system clock; all logic on rising edge
//  sys_rst_i      in   1   synchronous reset, active-low (0 = reset)
//  frame_start_i  in   1   pulse; begins next frame when IDLE (ignored otherwise)
//  fb_addr_o      out  15  framebuffer read address, y*H_RES+x
//  fb_rd_o        out  1   framebuffer read strobe; data valid exactly 1 cycle later
//  fb_data_i      in   16  RGB565 pixel
//  word_o         out  16  item to TFT_SPI; bytes occupy [7:0], [15:8]=0
//  word16_o       out  1   1 = 16-bit item, 0 = 8-bit item
//  dc_o           out  1   0 = command, 1 = data
//  word_valid_o   out  1   word_o/word16_o/dc_o valid
//  word_ready_i   in   1   TFT_SPI accepts item when valid&&ready
//  tft_rst_no     out  1   panel hardware reset, active-low
//  init_done_o    out  1   high once init ROM finished; stays high until reset
//  busy_o         out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset (sys_rst_i=0 at edge): state=RST_LOW, tft_rst_no=0, word_valid_o=0, fb_rd_o=0,
//   word_o=0, word16_o=0, dc_o=0, fb_addr_o=0, init_done_o=0, busy_o=1, timers/counters=0.
//   Reset mid-transfer drops word_valid_o the next cycle; no partial item is completed.
//  Handshake: transfer when word_valid_o&&word_ready_i at the edge. While valid&&!ready all
//   of word_o/word16_o/dc_o are held stable. Next item may assert valid the cycle after a
//   transfer (back-to-back accepted, 1 item/cycle max).
//  ms tick: free-running divider, 1-cycle pulse every CLK_FREQ_HZ/1000 cycles; ms counters
//   count ticks, so delays are accurate to -1 ms/+0.
//  FSM:
//   RST_LOW   : tft_rst_no=0 for RST_LOW_MS ticks -> RST_WAIT
//   RST_WAIT  : tft_rst_no=1 for RST_WAIT_MS ticks -> INIT_FETCH, rom_idx=0
//   INIT_FETCH: read ROM[rom_idx] (1-cycle latency) -> decode: type 00 cmd / 01 data ->
//               INIT_SEND (8-bit, dc=type[0]); 10 delay -> INIT_DELAY (data[7:0] ms);
//               11 end, or rom_idx==INIT_LEN -> IDLE, init_done_o=1
//   INIT_SEND : hold item until accepted -> rom_idx++ -> INIT_FETCH
//   INIT_DELAY: wait data ms ticks (0 = no wait) -> rom_idx++ -> INIT_FETCH
//   IDLE      : busy_o=0; frame_start_i -> WIN_SEND, win_idx=0
//   WIN_SEND  : 11 byte items in order: cmd 0x2A, data 00,00,00,H_RES-1, cmd 0x2B,
//               data 00,00,00,V_RES-1, cmd 0x2C; after 11th accept -> PIX_REQ, pix=0
//   PIX_REQ   : fb_rd_o=1 one cycle with fb_addr_o=pix -> PIX_SEND
//   PIX_SEND  : word_o=captured fb_data_i, word16_o=1, dc_o=1; on accept: pix==H_RES*V_RES-1
//               -> IDLE, pix=0; else pix++ -> PIX_REQ
//  fb_addr_o wraps to 0 only at frame end; never exceeds H_RES*V_RES-1.
//  frame_start_i outside IDLE is dropped (not queued); frame_start_i coincident with
//   init completion is dropped.
//  Pixel throughput: at most 1 pixel per 2 cycles (REQ+SEND); acceptable, SPI is slower.
// STRUCTURE
//  Package tft_pkg: ROM entry type encodings (CMD=2'b00, DATA=2'b01, DLY=2'b10, END=2'b11),
//   TFT command constants CASET=8'h2A, RASET=8'h2B, RAMWR=8'h2C, FSM state enum.
//  Sub-module tft_init_rom: INIT_LEN x 10-bit {type[1:0],byte[7:0]}, registered read,
//   contents from $readmemh("tft_init.mem").
//  Top: FSM, ms divider, ms/rom/win/pixel counters, output holding registers.
// TESTING (bench uses CLK_FREQ_HZ=4000 -> 4 cycles/ms, H_RES=4, V_RES=2, ready model)
//  1 Release reset, ready=1 -> tft_rst_no low 40 cycles (10 ms), then high; first
//    word_valid_o no earlier than 480 cycles later (120 ms).
//  2 ROM {CMD 01, DLY 5, CMD 11, DATA 3A, END} -> items (dc,byte) (0,01),(0,11),(1,3A);
//    >=20 cycles between 01 and 11 accepts; init_done_o=1, busy_o=0 after.
//  3 frame_start_i pulse -> 11 window items 2A,00,00,00,03,2B,00,00,00,01,2C with dc
//    0,1,1,1,1,0,1,1,1,1,0; then 8 pixels with fb_addr_o 0..7, word16_o=1, dc_o=1.
//  4 ready toggled pseudo-randomly -> every item held stable while stalled; sequence
//    identical to scenario 3; no duplicate or skipped fb addresses.
//  5 frame_start_i pulsed during pixel 3 -> ignored; second pulse in IDLE -> new frame
//    starting at fb_addr_o=0 with window prefix.
//  6 sys_rst_i=0 for 1 cycle mid-pixel-stream -> next cycle word_valid_o=0, tft_rst_no=0,
//    init_done_o=0; full reset/init sequence replays.

Source files
------------

// File: rtl/tft_pkg.sv
// Shared definitions for the TFT frame feeder: ROM entry encodings, panel
// command bytes, controller state codes and the built-in init image.
package tft_pkg;

  typedef enum logic [1:0] {
    ENT_CMD  = 2'b00,
    ENT_DATA = 2'b01,
    ENT_DLY  = 2'b10,
    ENT_END  = 2'b11
  } rom_type_t;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef logic [3:0] state_t;

  localparam state_t ST_RST_LOW    = 4'd0;
  localparam state_t ST_RST_WAIT   = 4'd1;
  localparam state_t ST_INIT_FETCH = 4'd2;
  localparam state_t ST_INIT_SEND  = 4'd3;
  localparam state_t ST_INIT_DELAY = 4'd4;
  localparam state_t ST_IDLE       = 4'd5;
  localparam state_t ST_WIN_SEND   = 4'd6;
  localparam state_t ST_PIX_REQ    = 4'd7;
  localparam state_t ST_PIX_SEND   = 4'd8;

  // Entry 0 sits in bits [9:0]. Each entry is {type[1:0], byte[7:0]}.
  // SWRESET, wait 150 ms, SLPOUT, wait 255 ms, COLMOD=RGB565, DISPON, end.
  localparam logic [79:0] DEFAULT_INIT_IMAGE = {
    10'h300, 10'h029, 10'h105, 10'h03A,
    10'h2FF, 10'h011, 10'h296, 10'h001
  };

endpackage

// File: rtl/tft_init_rom.sv
// Init command ROM: INIT_LEN entries of {type, byte} with a registered read.
// Addresses at or past INIT_LEN read back as an END entry.
module tft_init_rom
  import tft_pkg::*;
#(
  parameter int INIT_LEN = 32,
  parameter int IDX_W    = 6,
  parameter logic [INIT_LEN*10-1:0] IMAGE = '0
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr,
  output logic [9:0]       data
);

  // Registered lookup so the read behaves like a synchronous block RAM.
  always_ff @(posedge clk) begin
    if (int'(addr) < INIT_LEN) begin
      data <= IMAGE[int'(addr)*10 +: 10];
    end else begin
      data <= {ENT_END, 8'h00};
    end
  end

endmodule

// File: rtl/tft_frame_feeder.sv
// Upstream item source for the TFT SPI engine: panel hard reset, init ROM
// replay, address window programming and RGB565 pixel streaming over a
// valid/ready handshake.
module tft_frame_feeder
  import tft_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int H_RES       = 160,
  parameter int V_RES       = 128,
  parameter int INIT_LEN    = 32,
  parameter int RST_LOW_MS  = 10,
  parameter int RST_WAIT_MS = 120,
  parameter logic [INIT_LEN*10-1:0] INIT_IMAGE = (INIT_LEN*10)'(DEFAULT_INIT_IMAGE)
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        frame_start_i,
  output logic [14:0] fb_addr_o,
  output logic        fb_rd_o,
  input  logic [15:0] fb_data_i,
  output logic [15:0] word_o,
  output logic        word16_o,
  output logic        dc_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        tft_rst_no,
  output logic        init_done_o,
  output logic        busy_o
);

  localparam int DIV   = CLK_FREQ_HZ / 1000;
  localparam int DIV_W = $clog2(DIV + 1);
  localparam int IDX_W = $clog2(INIT_LEN + 1);
  localparam logic [14:0] PIX_LAST = 15'(H_RES * V_RES - 1);

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             ms_tick;
  logic [15:0]      ms_cnt;
  logic [7:0]       dly_ms;
  logic [IDX_W-1:0] rom_idx;
  logic             rom_phase;
  logic [9:0]       rom_q;
  rom_type_t        ent_type;
  logic [3:0]       win_idx;
  logic [14:0]      pix;
  logic [15:0]      word_q;
  logic             word16_q;
  logic             dc_q;
  logic             valid_q;
  logic             pix_first;
  logic             rst_n_q;
  logic             init_done_q;

  // Window programming sequence: CASET x0..x1, RASET y0..y1, RAMWR.
  function automatic logic [8:0] win_item(input logic [3:0] idx);
    logic [15:0] xe;
    logic [15:0] ye;
    xe = 16'(H_RES - 1);
    ye = 16'(V_RES - 1);
    case (idx)
      4'd0:       win_item = {1'b0, CMD_CASET};
      4'd1, 4'd2: win_item = {1'b1, 8'h00};
      4'd3:       win_item = {1'b1, xe[15:8]};
      4'd4:       win_item = {1'b1, xe[7:0]};
      4'd5:       win_item = {1'b0, CMD_RASET};
      4'd6, 4'd7: win_item = {1'b1, 8'h00};
      4'd8:       win_item = {1'b1, ye[15:8]};
      4'd9:       win_item = {1'b1, ye[7:0]};
      default:    win_item = {1'b0, CMD_RAMWR};
    endcase
  endfunction

  tft_init_rom #(
    .INIT_LEN (INIT_LEN),
    .IDX_W    (IDX_W),
    .IMAGE    (INIT_IMAGE)
  ) u_rom (
    .clk  (sys_clk_i),
    .addr (rom_idx),
    .data (rom_q)
  );

  assign ent_type = rom_type_t'(rom_q[9:8]);
  assign ms_tick  = (div_cnt == DIV_W'(DIV - 1));

  // Free-running millisecond divider producing a one-cycle tick.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      div_cnt <= '0;
    end else if (ms_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Main sequencer: reset timing, init replay, window and pixel streaming.
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i) begin
      state       <= ST_RST_LOW;
      ms_cnt      <= '0;
      dly_ms      <= '0;
      rom_idx     <= '0;
      rom_phase   <= 1'b0;
      win_idx     <= '0;
      pix         <= '0;
      word_q      <= '0;
      word16_q    <= 1'b0;
      dc_q        <= 1'b0;
      valid_q     <= 1'b0;
      pix_first   <= 1'b0;
      rst_n_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state)
        ST_RST_LOW: begin
          if (ms_tick) begin
            if (ms_cnt == 16'(RST_LOW_MS - 1)) begin
              ms_cnt  <= '0;
              rst_n_q <= 1'b1;
              state   <= ST_RST_WAIT;
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
            end
          end
        end
        ST_RST_WAIT: begin
          if (ms_tick) begin
            if (ms_cnt == 16'(RST_WAIT_MS - 1)) begin
              ms_cnt    <= '0;
              rom_idx   <= '0;
              rom_phase <= 1'b0;
              state     <= ST_INIT_FETCH;
            end else begin
              ms_cnt <= ms_cnt + 1'b1;
            end
          end
        end
        ST_INIT_FETCH: begin
          if (!rom_phase) begin
            if (rom_idx == IDX_W'(INIT_LEN)) begin
              init_done_q <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              rom_phase <= 1'b1;
            end
          end else begin
            rom_phase <= 1'b0;
            case (ent_type)
              ENT_CMD, ENT_DATA: begin
                word_q   <= {8'h00, rom_q[7:0]};
                word16_q <= 1'b0;
                dc_q     <= rom_q[8];
                valid_q  <= 1'b1;
                state    <= ST_INIT_SEND;
              end
              ENT_DLY: begin
                ms_cnt <= '0;
                dly_ms <= rom_q[7:0];
                state  <= ST_INIT_DELAY;
              end
              default: begin
                init_done_q <= 1'b1;
                state       <= ST_IDLE;
              end
            endcase
          end
        end
        ST_INIT_SEND: begin
          if (word_ready_i) begin
            valid_q <= 1'b0;
            rom_idx <= rom_idx + 1'b1;
            state   <= ST_INIT_FETCH;
          end
        end
        ST_INIT_DELAY: begin
          if (ms_cnt == {8'h00, dly_ms}) begin
            rom_idx <= rom_idx + 1'b1;
            state   <= ST_INIT_FETCH;
          end else if (ms_tick) begin
            ms_cnt <= ms_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (frame_start_i) begin
            win_idx  <= '0;
            word_q   <= {8'h00, win_item(4'd0)};
            word_q[8] <= 1'b0;
            dc_q     <= win_item(4'd0) >> 8 != 9'd0;
            word16_q <= 1'b0;
            valid_q  <= 1'b1;
            state    <= ST_WIN_SEND;
          end
        end
        ST_WIN_SEND: begin
          if (word_ready_i) begin
            if (win_idx == 4'd10) begin
              valid_q <= 1'b0;
              pix     <= '0;
              state   <= ST_PIX_REQ;
            end else begin
              win_idx <= win_idx + 4'd1;
              word_q  <= {8'h00, win_item(win_idx + 4'd1)};
              word_q[8] <= 1'b0;
              dc_q    <= win_item(win_idx + 4'd1) >> 8 != 9'd0;
            end
          end
        end
        ST_PIX_REQ: begin
          pix_first <= 1'b1;
          word16_q  <= 1'b1;
          dc_q      <= 1'b1;
          valid_q   <= 1'b1;
          state     <= ST_PIX_SEND;
        end
        ST_PIX_SEND: begin
          pix_first <= 1'b0;
          if (pix_first) begin
            word_q <= fb_data_i;
          end
          if (word_ready_i) begin
            valid_q <= 1'b0;
            if (pix == PIX_LAST) begin
              pix   <= '0;
              state <= ST_IDLE;
            end else begin
              pix   <= pix + 1'b1;
              state <= ST_PIX_REQ;
            end
          end
        end
        default: state <= ST_RST_LOW;
      endcase
    end
  end

  // The pixel word passes straight through in its read-data cycle and is
  // held from the captured copy while the SPI side stalls.
  assign word_o       = pix_first ? fb_data_i : word_q;
  assign word16_o     = word16_q;
  assign dc_o         = dc_q;
  assign word_valid_o = valid_q;
  assign fb_rd_o      = (state == ST_PIX_REQ);
  assign fb_addr_o    = pix;
  assign tft_rst_no   = rst_n_q;
  assign init_done_o  = init_done_q;
  assign busy_o       = (state != ST_IDLE);

endmodule
